trisc_datapath: RTL and testbench

//  Register-level datapath driven by controller2's control strobes (c0..c15); returns decoded opcode flags d0..d10.

---
 rtl/trisc_pkg.sv | 26 ++
 rtl/trisc_datapath_if.sv | 35 +++
 rtl/trisc_opdecode.sv | 20 ++
 rtl/trisc_datapath.sv | 127 ++++++++++++
 tb/tb_trisc_datapath.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/trisc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : trisc_pkg
//  Brief    : Shared constants and opcode encoding for the TRISC datapath.
//  Revision : 1.0  initial release
// ============================================================================
package trisc_pkg;

    // Default widths; an instruction is {opcode[3:0], addr[ADDR_W-1:0]}
    localparam int c_DATA_W_DFLT = 8;
    localparam int c_ADDR_W_DFLT = 4;
    localparam int c_OPCODE_W    = 4;
    localparam int c_NUM_DECODE  = 11;

    // Opcodes with defined behaviour; 3, 4, 8, 9, 10 decode but are reserved
    typedef enum logic [c_OPCODE_W-1:0] {
        OP_LDA = 4'd0,
        OP_STA = 4'd1,
        OP_ADD = 4'd2,
        OP_INC = 4'd5,
        OP_CLR = 4'd6,
        OP_JMP = 4'd7
    } opcode_e;

endpackage : trisc_pkg
`default_nettype wire

// File: rtl/trisc_datapath_if.sv
`default_nettype none
// ============================================================================
//  Module   : trisc_datapath_if
//  Brief    : Synchronous memory port between TRISC datapath and memory.
//  Revision : 1.0  initial release
// ============================================================================
interface trisc_datapath_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_re;
    logic              mem_we;

    // Datapath side drives address/controls, consumes read data
    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_re,
        output mem_we,
        input  mem_rdata
    );

    // Memory side
    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_re,
        input  mem_we,
        output mem_rdata
    );
endinterface : trisc_datapath_if
`default_nettype wire

// File: rtl/trisc_opdecode.sv
`default_nettype none
// ============================================================================
//  Module   : trisc_opdecode
//  Brief    : 4-bit opcode to 11-bit one-hot decode; opcodes 11..15 give 0.
//  Revision : 1.0  initial release
// ============================================================================
module trisc_opdecode
    import trisc_pkg::*;
(
    input  logic [c_OPCODE_W-1:0]   i_opcode,
    output logic [c_NUM_DECODE-1:0] o_d
);

    // One comparator per decoded opcode
    for (genvar i = 0; i < c_NUM_DECODE; i++) begin : g_dec
        assign o_d[i] = (i_opcode == c_OPCODE_W'(i));
    end

endmodule : trisc_opdecode
`default_nettype wire

// File: rtl/trisc_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : trisc_datapath
//  Brief    : TRISC register datapath (PC, IR, AC, B, carry) steered by the
//             controller strobes; returns one-hot opcode decode.
//  Revision : 1.0  initial release
// ============================================================================
module trisc_datapath
    import trisc_pkg::*;
#(
    parameter int DATA_W = c_DATA_W_DFLT,
    parameter int ADDR_W = c_ADDR_W_DFLT
)(
    input  logic              Clock,
    input  logic              reset,
    input  logic              c0,
    input  logic              c1,
    input  logic              c2,
    input  logic              c3,
    input  logic              c4,
    input  logic              c5,
    input  logic              c7,
    input  logic              c8,
    input  logic              c9,
    input  logic              c10,
    input  logic              c11,
    input  logic              c12,
    input  logic              c13,
    input  logic              c14,
    input  logic              c15,
    output logic              d0,
    output logic              d1,
    output logic              d2,
    output logic              d3,
    output logic              d4,
    output logic              d5,
    output logic              d6,
    output logic              d7,
    output logic              d8,
    output logic              d9,
    output logic              d10,
    trisc_datapath_if.master  mem,
    output logic [ADDR_W-1:0] pc_out,
    output logic [DATA_W-1:0] acc_out,
    output logic              carry
);

    logic [ADDR_W-1:0]       r_pc;
    logic [DATA_W-1:0]       r_ir;
    logic [DATA_W-1:0]       r_ac;
    logic [DATA_W-1:0]       r_b;
    logic                    r_carry;
    logic [DATA_W:0]         w_sum;
    logic [c_NUM_DECODE-1:0] w_d;

    // Reserved strobes carry no function in this revision
    logic w_unused;
    assign w_unused = &{1'b0, c12, c13, c15};

    // Program counter: clear beats jump beats increment
    always_ff @(posedge Clock or negedge reset) begin
        if (!reset)
            r_pc <= '0;
        else if (c0)
            r_pc <= '0;
        else if (c1)
            r_pc <= r_ir[ADDR_W-1:0];
        else if (c7)
            r_pc <= r_pc + ADDR_W'(1);
    end

    // Instruction register loads from the memory read data
    always_ff @(posedge Clock or negedge reset) begin
        if (!reset)
            r_ir <= '0;
        else if (c2)
            r_ir <= mem.mem_rdata;
    end

    // ALU operand register loads from the memory read data
    always_ff @(posedge Clock or negedge reset) begin
        if (!reset)
            r_b <= '0;
        else if (c14)
            r_b <= mem.mem_rdata;
    end

    // Full-width add so the carry-out lands in the top bit
    assign w_sum = {1'b0, r_ac} + {1'b0, r_b};

    // Accumulator and carry: CLR beats INC beats ADD/LDA; c10 alone does nothing
    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            r_ac    <= '0;
            r_carry <= 1'b0;
        end else if (c8) begin
            r_ac    <= '0;
            r_carry <= 1'b0;
        end else if (c9) begin
            r_ac    <= r_ac + DATA_W'(1);
        end else if (c11 && c10) begin
            r_ac    <= w_sum[DATA_W-1:0];
            r_carry <= w_sum[DATA_W];
        end else if (c11) begin
            r_ac    <= mem.mem_rdata;
        end
    end

    trisc_opdecode u_opdecode (
        .i_opcode (r_ir[DATA_W-1 -: c_OPCODE_W]),
        .o_d      (w_d)
    );

    assign {d10, d9, d8, d7, d6, d5, d4, d3, d2, d1, d0} = w_d;

    // Operand address during execute, program counter otherwise
    assign mem.mem_addr  = c3 ? r_ir[ADDR_W-1:0] : r_pc;
    assign mem.mem_wdata = r_ac;
    assign mem.mem_re    = c4;
    assign mem.mem_we    = c5;

    assign pc_out  = r_pc;
    assign acc_out = r_ac;
    assign carry   = r_carry;

endmodule : trisc_datapath
`default_nettype wire

// File: tb/tb_trisc_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : tb_trisc_datapath
//  Brief    : Directed scoreboard bench for trisc_datapath.
//  Revision : 1.0  initial release
// ============================================================================
module tb_trisc_datapath;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;

    logic Clock = 1'b0;
    logic reset = 1'b1;
    logic c0, c1, c2, c3, c4, c5, c7, c8, c9, c10, c11, c12, c13, c14, c15;
    logic d0, d1, d2, d3, d4, d5, d6, d7, d8, d9, d10;
    logic [ADDR_W-1:0] pc_out;
    logic [DATA_W-1:0] acc_out;
    logic              carry;

    trisc_datapath_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mem_if ();

    trisc_datapath #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .Clock(Clock), .reset(reset),
        .c0(c0), .c1(c1), .c2(c2), .c3(c3), .c4(c4), .c5(c5),
        .c7(c7), .c8(c8), .c9(c9), .c10(c10), .c11(c11),
        .c12(c12), .c13(c13), .c14(c14), .c15(c15),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5),
        .d6(d6), .d7(d7), .d8(d8), .d9(d9), .d10(d10),
        .mem(mem_if.master),
        .pc_out(pc_out), .acc_out(acc_out), .carry(carry)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        string       tag;
        logic [15:0] exp;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [15:0] observe(input string tag);
        logic [15:0] v;
        v = 16'hDEAD;
        if      (tag == "pc")    v = 16'(pc_out);
        else if (tag == "ac")    v = 16'(acc_out);
        else if (tag == "carry") v = 16'(carry);
        else if (tag == "d")     v = 16'({d10, d9, d8, d7, d6, d5, d4, d3, d2, d1, d0});
        else if (tag == "addr")  v = 16'(mem_if.mem_addr);
        else if (tag == "wdata") v = 16'(mem_if.mem_wdata);
        else if (tag == "re")    v = 16'(mem_if.mem_re);
        else if (tag == "we")    v = 16'(mem_if.mem_we);
        return v;
    endfunction

    task automatic expect_v(input string tag, input logic [15:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    // Pop every pending expectation and compare with the DUT now
    task automatic check_all();
        exp_t        e;
        logic [15:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.tag);
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    // Clock edge, then sample away from it
    task automatic step();
        @(posedge Clock);
        #1;
        check_all();
    endtask

    // Combinational/asynchronous check without a clock edge
    task automatic settle();
        #1;
        check_all();
    endtask

    task automatic idle();
        {c0, c1, c2, c3, c4, c5, c7, c8, c9, c10, c11, c12, c13, c14, c15} = '0;
    endtask

    task automatic rand_strobes();
        {c0, c1, c2, c3, c4, c5, c7, c8, c9, c10, c11, c12, c13, c14, c15} = 15'($urandom);
        mem_if.mem_rdata = 8'($urandom);
    endtask

    initial begin
        idle();
        mem_if.mem_rdata = '0;

        // Reset with random strobes
        #2;
        reset = 1'b0;
        rand_strobes();
        expect_v("pc", 0); expect_v("ac", 0); expect_v("carry", 0); expect_v("d", 16'h001);
        settle();
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            rand_strobes();
        end
        expect_v("pc", 0); expect_v("ac", 0); expect_v("carry", 0); expect_v("d", 16'h001);
        step();
        idle();
        reset = 1'b1;
        expect_v("pc", 0); expect_v("ac", 0); expect_v("d", 16'h001);
        step();

        // Fetch: two read cycles at PC, then load IR and bump PC
        c4 = 1'b1;
        expect_v("addr", 0); expect_v("re", 1); expect_v("we", 0);
        settle();
        expect_v("addr", 0); expect_v("re", 1);
        step();
        c4 = 1'b0; c2 = 1'b1; c7 = 1'b1; mem_if.mem_rdata = 8'h53;
        expect_v("d", 16'h020); expect_v("pc", 1);
        step();
        idle(); mem_if.mem_rdata = 8'hFF;
        expect_v("d", 16'h020); expect_v("pc", 1);
        step();

        // PC increment to F, then wrap
        c7 = 1'b1;
        for (int i = 0; i < 13; i++) @(posedge Clock);
        expect_v("pc", 16'hF);
        step();
        expect_v("pc", 0);
        step();

        // JMP beats increment, clear beats JMP
        idle(); c2 = 1'b1; mem_if.mem_rdata = 8'h7A;
        expect_v("d", 16'h080);
        step();
        idle(); c1 = 1'b1; c7 = 1'b1;
        expect_v("pc", 16'hA);
        step();
        c0 = 1'b1; c7 = 1'b0;
        expect_v("pc", 0);
        step();

        // LDA, load B, ADD with carry-out, c10 alone is inert
        idle(); c11 = 1'b1; mem_if.mem_rdata = 8'hF0;
        expect_v("ac", 16'hF0); expect_v("carry", 0);
        step();
        idle(); c14 = 1'b1; mem_if.mem_rdata = 8'h20;
        expect_v("ac", 16'hF0);
        step();
        idle(); c10 = 1'b1; c11 = 1'b1; mem_if.mem_rdata = 8'h99;
        expect_v("ac", 16'h10); expect_v("carry", 1);
        step();
        idle(); c10 = 1'b1;
        expect_v("ac", 16'h10); expect_v("carry", 1);
        step();

        // STA: operand address, write data, both enables
        idle(); c11 = 1'b1; mem_if.mem_rdata = 8'h3C;
        expect_v("ac", 16'h3C); expect_v("carry", 1);
        step();
        idle(); c2 = 1'b1; mem_if.mem_rdata = 8'h19;
        expect_v("d", 16'h002);
        step();
        idle(); c3 = 1'b1; c4 = 1'b1; c5 = 1'b1;
        expect_v("addr", 16'h9); expect_v("wdata", 16'h3C); expect_v("we", 1); expect_v("re", 1);
        settle();
        c3 = 1'b0;
        expect_v("addr", 0);
        settle();

        // INC wraps without touching carry; CLR beats INC and LDA
        idle(); c11 = 1'b1; mem_if.mem_rdata = 8'hFF;
        expect_v("ac", 16'hFF);
        step();
        idle(); c9 = 1'b1;
        expect_v("ac", 0); expect_v("carry", 1);
        step();
        expect_v("ac", 1); expect_v("carry", 1);
        step();
        idle(); c8 = 1'b1; c9 = 1'b1; c11 = 1'b1; mem_if.mem_rdata = 8'h55;
        expect_v("ac", 0); expect_v("carry", 0);
        step();

        // Decode boundaries: opcode 10 and out-of-range opcode 12
        idle(); c2 = 1'b1; mem_if.mem_rdata = 8'hA1;
        expect_v("d", 16'h400);
        step();
        mem_if.mem_rdata = 8'hC3;
        expect_v("d", 16'h000);
        step();

        // Asynchronous reset mid-instruction clears without a clock edge
        idle(); c11 = 1'b1; c7 = 1'b1; mem_if.mem_rdata = 8'h77;
        expect_v("ac", 16'h77); expect_v("pc", 1);
        step();
        c11 = 1'b0; c10 = 1'b1; c14 = 1'b1;
        #1;
        reset = 1'b0;
        expect_v("ac", 0); expect_v("pc", 0); expect_v("carry", 0); expect_v("d", 16'h001);
        settle();
        idle(); c9 = 1'b1; c7 = 1'b1;
        expect_v("ac", 0); expect_v("pc", 0);
        step();
        idle();
        reset = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_trisc_datapath
`default_nettype wire
